// File: rtl/fp16_defs.sv
// FP16 (binary16) format constants, field positions and accumulator state encoding.
// Shared by the accumulate stage and any future FP16 arithmetic blocks.
package fp16_defs;

    localparam int          FP16_BIAS     = 15;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
    localparam logic [15:0] FP16_PINF     = 16'h7C00;
    localparam logic [15:0] FP16_ZERO     = 16'h0000;

    localparam int FP16_SIGN     = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_FRAC_MSB = 9;
    localparam int FP16_FRAC_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    // 14-bit working magnitude {hidden, frac, 3 guard zeros}; exp=0 reads as zero.
    function automatic logic [13:0] fp16_mag(input logic [14:0] x);
        logic [4:0] e;
        e = x[FP16_EXP_MSB:FP16_EXP_LSB];
        return (e == 5'd0) ? 14'd0 : {1'b1, x[FP16_FRAC_MSB:FP16_FRAC_LSB], 3'b000};
    endfunction

endpackage

// File: rtl/fp16_accumulator_if.sv
// Operand-in / sum-out handshake bundle for the FP16 accumulate stage.
// master = upstream multiplier + downstream consumer side, slave = accumulator.
interface fp16_accumulator_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ovf;

    modport master (
        output in_valid, in_data, in_last, acc_clear, out_ready,
        input  in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, acc_clear, out_ready,
        output in_ready, out_valid, out_data, ovf
    );

endinterface

// File: rtl/fp16_lzc14.sv
// Combinational 14-bit leading-zero counter; all-zero input returns 14.
// No latency, no handshake.
module fp16_lzc14 (
    input  logic [13:0] value,
    output logic [3:0]  count
);

    always_comb begin
        count = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (value[i]) count = 4'(13 - i);
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// Sequential FP16 running-sum stage: ALIGN/ADD/NORM per operand, sum presented on group last.
// One operand per 4 cycles; in_ready low while busy or while a finished sum waits for out_ready.
module fp16_accumulator
    import fp16_defs::*;
(
    input  logic CLK,
    input  logic RESETn,
    fp16_accumulator_if.slave bus
);

    state_t      state;
    logic [15:0] acc;
    logic [15:0] op;
    logic        last_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic        ovf_q;

    logic [4:0]  al_exp;
    logic [13:0] al_big;
    logic [13:0] al_sml;
    logic        al_big_s;
    logic        al_sml_s;
    logic        sp_q;
    logic [15:0] sp_val;

    logic [14:0] sum_m;
    logic        sum_s;
    logic [4:0]  sum_exp;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;

    // Align: larger exponent wins, the other magnitude is right-shifted with truncation.
    logic [4:0]  a_e, b_e, big_e, diff;
    logic [13:0] a_m, b_m, big_m, sml_m, sml_sh;
    logic        big_s, sml_s, acc_inf, op_inf;

    always_comb begin
        a_e     = acc[FP16_EXP_MSB:FP16_EXP_LSB];
        b_e     = op[FP16_EXP_MSB:FP16_EXP_LSB];
        a_m     = fp16_mag(acc[14:0]);
        b_m     = fp16_mag(op[14:0]);
        acc_inf = (a_e == FP16_EXP_MAX);
        op_inf  = (b_e == FP16_EXP_MAX);
        if (a_e >= b_e) begin
            big_e = a_e;  big_m = a_m;  big_s = acc[FP16_SIGN];
            sml_m = b_m;  sml_s = op[FP16_SIGN];
            diff  = a_e - b_e;
        end else begin
            big_e = b_e;  big_m = b_m;  big_s = op[FP16_SIGN];
            sml_m = a_m;  sml_s = acc[FP16_SIGN];
            diff  = b_e - a_e;
        end
        sml_sh = (diff >= 5'd14) ? 14'd0 : (sml_m >> diff);
    end

    logic [14:0] add_m;
    logic        add_s;

    always_comb begin
        if (al_big_s == al_sml_s) begin
            add_m = {1'b0, al_big} + {1'b0, al_sml};
            add_s = al_big_s;
        end else if (al_big >= al_sml) begin
            add_m = {1'b0, al_big} - {1'b0, al_sml};
            add_s = al_big_s;
        end else begin
            add_m = {1'b0, al_sml} - {1'b0, al_big};
            add_s = al_sml_s;
        end
        if (add_m == 15'd0) add_s = 1'b0;
    end

    logic [3:0]         lz;
    logic [13:0]        norm_m;
    logic signed [6:0]  norm_e;
    logic [9:0]         norm_frac;
    logic [15:0]        res;
    logic               res_ovf;

    fp16_lzc14 u_lzc (
        .value (sum_m[13:0]),
        .count (lz)
    );

    always_comb begin
        if (sum_m[14]) begin
            norm_m = sum_m[14:1];
            norm_e = $signed({2'b00, sum_exp}) + 7'sd1;
        end else begin
            norm_m = sum_m[13:0] << lz;
            norm_e = $signed({2'b00, sum_exp}) - $signed({3'b000, lz});
        end
        norm_frac = 10'(norm_m >> 3);
        res_ovf   = 1'b0;
        if (sp_q) begin
            res     = sp_val;
            res_ovf = 1'b1;
        end else if (sum_m == 15'd0 || norm_e <= 7'sd0) begin
            res = FP16_ZERO;
        end else if (norm_e >= 7'sd31) begin
            res     = FP16_PINF | {sum_s, 15'd0};
            res_ovf = 1'b1;
        end else begin
            res = {sum_s, norm_e[4:0], norm_frac};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= ST_IDLE;
            acc         <= FP16_ZERO;
            op          <= FP16_ZERO;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= FP16_ZERO;
            ovf_q       <= 1'b0;
            al_exp      <= 5'd0;
            al_big      <= 14'd0;
            al_sml      <= 14'd0;
            al_big_s    <= 1'b0;
            al_sml_s    <= 1'b0;
            sp_q        <= 1'b0;
            sp_val      <= FP16_ZERO;
            sum_m       <= 15'd0;
            sum_s       <= 1'b0;
            sum_exp     <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.acc_clear) begin
                        acc   <= FP16_ZERO;
                        ovf_q <= 1'b0;
                    end
                    if (bus.in_valid && in_ready_q) begin
                        op         <= bus.in_data;
                        last_q     <= bus.in_last;
                        in_ready_q <= 1'b0;
                        state      <= ST_ALIGN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    al_exp   <= big_e;
                    al_big   <= big_m;
                    al_sml   <= sml_sh;
                    al_big_s <= big_s;
                    al_sml_s <= sml_s;
                    // An infinite running sum is sticky; otherwise an infinite operand takes over.
                    sp_q     <= acc_inf | op_inf;
                    sp_val   <= acc_inf ? acc : (FP16_PINF | {op[FP16_SIGN], 15'd0});
                    state    <= ST_ADD;
                end
                ST_ADD: begin
                    sum_m   <= add_m;
                    sum_s   <= add_s;
                    sum_exp <= al_exp;
                    state   <= ST_NORM;
                end
                ST_NORM: begin
                    acc <= res;
                    if (res_ovf) ovf_q <= 1'b1;
                    if (last_q) begin
                        state <= ST_DONE;
                    end else begin
                        state      <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= FP16_ZERO;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator: hand-computed FP16 sums, latency, backpressure and reset.
module tb_fp16_accumulator;

    logic CLK;
    logic RESETn;
    int   checks = 0;
    int   fails  = 0;

    fp16_accumulator_if bus ();

    fp16_accumulator dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l, output int waited);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            fails++;
            $error("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_sum, input logic exp_ovf);
        int w, k;
        send(a, 1'b0, w);
        send(b, 1'b1, w);
        wait_out(k);
        check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
        check({tag, "_data"}, bus.out_data, exp_sum);
        check({tag, "_ovf"}, {15'd0, bus.ovf}, {15'd0, exp_ovf});
        take_out();
        check({tag, "_drop"}, {15'd0, bus.out_valid}, 16'd0);
    endtask

    initial begin
        int w, k;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b0;
        RESETn        = 1'b1;
        #2 RESETn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready",  {15'd0, bus.in_ready},  16'd0);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out_data",  bus.out_data,           16'h0000);
        check("rst_ovf",       {15'd0, bus.ovf},       16'd0);
        #4 RESETn = 1'b1;
        @(posedge CLK); #1;
        check("in_ready_rise", {15'd0, bus.in_ready}, 16'd1);

        // 1.0 + 2.0 = 3.0, with throughput and output latency
        send(16'h3C00, 1'b0, w);
        send(16'h4000, 1'b1, w);
        check("accept_interval", 16'(w + 1), 16'd4);
        wait_out(k);
        check("out_latency", 16'(k), 16'd4);
        check("sum3_data", bus.out_data, 16'h4200);
        check("sum3_ovf", {15'd0, bus.ovf}, 16'd0);
        take_out();
        check("sum3_drop", {15'd0, bus.out_valid}, 16'd0);

        run_pair("cancel",  16'h3E00, 16'hBE00, 16'h0000, 1'b0);
        run_pair("sub",     16'h4000, 16'hBC00, 16'h3C00, 1'b0);
        run_pair("ovf",     16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);
        check("ovf_cleared", {15'd0, bus.ovf}, 16'd0);

        send(16'h3C00, 1'b1, w);
        wait_out(k);
        check("after_ovf_data", bus.out_data, 16'h3C00);
        check("after_ovf_ovf", {15'd0, bus.ovf}, 16'd0);
        take_out();

        run_pair("align14", 16'h3C00, 16'h0400, 16'h3C00, 1'b0);
        run_pair("exp0",    16'h3C00, 16'h0001, 16'h3C00, 1'b0);
        run_pair("inf_op",  16'h7C00, 16'h3C00, 16'h7C00, 1'b1);
        run_pair("inf_keep", 16'hFC00, 16'h7C00, 16'hFC00, 1'b1);

        // Clear together with an accept: the operand lands on a zeroed accumulator.
        send(16'h3C00, 1'b0, w);
        bus.acc_clear = 1'b1;
        send(16'h4000, 1'b1, w);
        bus.acc_clear = 1'b0;
        wait_out(k);
        check("clear_accept", bus.out_data, 16'h4000);
        take_out();

        // Clear while busy must be ignored.
        send(16'h3C00, 1'b0, w);
        bus.acc_clear = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.acc_clear = 1'b0;
        send(16'h3C00, 1'b1, w);
        wait_out(k);
        check("clear_busy", bus.out_data, 16'h4000);
        take_out();

        // Output backpressure: everything holds while out_ready stays low.
        send(16'h3C00, 1'b1, w);
        wait_out(k);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {15'd0, bus.out_valid}, 16'd1);
            check("hold_data", bus.out_data, 16'h3C00);
            check("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
            @(posedge CLK); #1;
        end
        take_out();
        send(16'h3C00, 1'b1, w);
        wait_out(k);
        check("restart_data", bus.out_data, 16'h3C00);
        take_out();

        // Reset during ADD with ovf set and a stale nonzero out_data.
        send(16'h7C00, 1'b0, w);
        send(16'h3C00, 1'b1, w);
        @(posedge CLK); #1;
        check("pre_rst_ovf", {15'd0, bus.ovf}, 16'd1);
        RESETn = 1'b0;
        #1;
        check("mid_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mid_rst_out_data",  bus.out_data,           16'h0000);
        check("mid_rst_ovf",       {15'd0, bus.ovf},       16'd0);
        check("mid_rst_in_ready",  {15'd0, bus.in_ready},  16'd0);
        @(posedge CLK);
        #5 RESETn = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        send(16'h4000, 1'b1, w);
        wait_out(k);
        check("post_rst_data", bus.out_data, 16'h4000);
        check("post_rst_ovf", {15'd0, bus.ovf}, 16'd0);
        take_out();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fp16_accumulator.md
# fp16_accumulator

Sequential FP16 accumulate stage that sits directly downstream of the registered FP16 multiplier in the float MAC datapath. It consumes one product per handshake and adds it into an internal FP16 running sum using a multi-cycle align/add/normalize state machine. It presents the sum on an output handshake when the last product of a dot-product group has been absorbed. Number format rules match the multiplier: IEEE-754 binary16 layout, bias 15, truncation rounding, no subnormals.

## Interface
- Parameters: none. Widths are fixed by the FP16 format.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_last are valid this cycle.
- in_ready  out  1  block can accept an operand. Registered; reset value 0.
- in_data  in  16  FP16 product from the multiplier.
- in_last  in  1  marks the final product of the group.
- acc_clear  in  1  zero the accumulator. Honoured only in IDLE; ignored in all other states.
- out_valid  out  1  out_data holds a completed group sum. Reset value 0.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  16  accumulated FP16 sum. Reset value 16'h0000.
- ovf  out  1  sticky flag, set when any operand had exp=31 or the sum overflowed. Cleared by group completion or acc_clear. Reset value 0.

## Operation
- **States:** IDLE, ALIGN, ADD, NORM, DONE. Reset forces IDLE and acc=0.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready: latch the operand and in_last, go to ALIGN, and drop in_ready.
  - If acc_clear and in_valid are both high in the same cycle: the clear applies first, then the operand is accepted against acc=0.
- **ALIGN:**
  - Each operand becomes a 14-bit magnitude {hidden,frac[9:0],3'b000}. The hidden bit is 0 and the magnitude is 0 when exp=0, so operands with exp=0 are treated as zero.
  - The larger-exponent operand fixes the result exponent. The other magnitude shifts right by the exponent difference; bits shifted past bit 0 are dropped. A difference of 14 or more gives 0.
- **ADD:**
  - Same signs: 15-bit add.
  - Different signs: subtract the smaller magnitude from the larger; the result sign is the larger one's sign.
  - Equal magnitudes with opposite signs give +0.
- **NORM:**
  - If bit14 is set: shift right 1 and exp+1.
  - Otherwise: shift left by the leading-zero count of bits[13:0] and subtract that count from exp.
  - Zero magnitude, or exp≤0 after adjustment: result is +0 (flush).
  - exp≥31: result is sign|0x7C00 and ovf is set.
  - The result keeps fraction bits [12:3] (truncation). It is written to acc.
  - From NORM: go to DONE if the latched last was 1, else go to IDLE.
- **Infinity operand:** any operand with exp=31 forces acc=sign|0x7C00 and sets ovf. The sum stays 0x7C00|sign for the rest of the group; later operands do not change it.
- **DONE:**
  - out_valid=1 and out_data=acc; both are held stable until out_ready.
  - On out_valid&out_ready: acc←0, ovf←0, out_valid←0, go to IDLE.
- **Reset mid-operation:** asynchronous; the in-flight operand is lost and all outputs return to their reset values.

## Timing
- Accept edge to the next in_ready=1: 4 cycles (ALIGN, ADD, NORM, IDLE). Peak throughput is one operand per 4 cycles.
- Last operand accepted at edge N: out_valid=1 after edge N+4. The earliest next accept is the cycle after the output handshake.
- in_ready rises on the first rising edge after RESETn deasserts.
- out_data is registered and never changes while out_valid=1.

## Structure
- Shared package / defines file fp16_defs holds:
  - FP16_BIAS=15, FP16_EXP_MAX=5'h1F, FP16_PINF=16'h7C00, FP16_ZERO=16'h0000.
  - Field slice ranges: sign 15, exp 14:10, frac 9:0.
  - The state encoding.
- Sub-module fp16_lzc14: combinational 14-bit leading-zero counter with a 4-bit count output. It is used by NORM and is reusable by a future FP16 adder.

## Test plan
- Sum 0x3C00 then 0x4000 with last=1 → out_data=0x4200 (3.0), ovf=0, out_valid rises 4 cycles after the last accept.
- Sum 0x3E00 then 0xBE00 (last) → 0x0000. Sum 0x4000 then 0xBC00 (last) → 0x3C00.
- Sum 0x7BFF then 0x7BFF (last) → 0x7C00, ovf=1. A following group 0x3C00 (last) → 0x3C00, ovf=0.
- Sum 0x3C00 then 0x0400 (last) → 0x3C00 (alignment shift ≥14 drops the smaller operand). An operand of 0x0001 is treated as zero.
- out_ready held low for 5 cycles in DONE → out_data and out_valid stable and in_ready=0 throughout. After out_ready, the accumulator restarts from 0.
- RESETn pulsed low during ADD → out_valid=0, out_data=0, ovf=0, in_ready=0 immediately. The next group gives a correct sum from 0.
